// File: rtl/sw_core_arbiter.sv
// Shares one Smith-Waterman core between two requesters with round-robin grant,
// job latching, core handshakes, a completion watchdog and result return.
module sw_core_arbiter #(
  parameter int SEQ_W   = 256,
  parameter int LEN_W   = 8,
  parameter int SCORE_W = 10,
  parameter int POS_W   = 7,
  parameter int MAX_LEN = 128,
  parameter int TIMEOUT = 65535
) (
  input  logic               avm_clk,
  input  logic               avm_rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [SEQ_W-1:0]   req0_ref,
  input  logic [SEQ_W-1:0]   req0_read,
  input  logic [LEN_W-1:0]   req0_ref_len,
  input  logic [LEN_W-1:0]   req0_read_len,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [SEQ_W-1:0]   req1_ref,
  input  logic [SEQ_W-1:0]   req1_read,
  input  logic [LEN_W-1:0]   req1_ref_len,
  input  logic [LEN_W-1:0]   req1_read_len,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [SCORE_W-1:0] rsp0_score,
  output logic [POS_W-1:0]   rsp0_row,
  output logic [POS_W-1:0]   rsp0_col,
  output logic               rsp0_err,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [SCORE_W-1:0] rsp1_score,
  output logic [POS_W-1:0]   rsp1_row,
  output logic [POS_W-1:0]   rsp1_col,
  output logic               rsp1_err,
  output logic               core_i_valid,
  input  logic               core_o_ready,
  output logic [SEQ_W-1:0]   core_seq_ref,
  output logic [SEQ_W-1:0]   core_seq_read,
  output logic [LEN_W-1:0]   core_ref_len,
  output logic [LEN_W-1:0]   core_read_len,
  output logic               core_i_ready,
  input  logic               core_o_valid,
  input  logic [SCORE_W-1:0] core_score,
  input  logic [POS_W-1:0]   core_row,
  input  logic [POS_W-1:0]   core_col,
  output logic               busy,
  output logic [15:0]        jobs_done
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic               last_grant, grant, pick, accept, zero_len, rsp_hs;
  logic [SEQ_W-1:0]   sel_ref, sel_read, ref_q, read_q;
  logic [LEN_W-1:0]   sel_ref_len, sel_read_len, ref_len_q, read_len_q;
  logic [SCORE_W-1:0] score_q;
  logic [POS_W-1:0]   row_q, col_q;
  logic               err_q;
  logic [WD_W-1:0]    wd;
  logic [15:0]        jobs_q;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > MAX_LEN_L) return MAX_LEN_L;
    return len;
  endfunction

  always_comb begin
    pick = 1'b0;
    if (req0_valid && req1_valid) pick = ~last_grant;
    else if (!req0_valid)         pick = 1'b1;
    // ready is combinational but must never fire while reset is held
    accept       = (state == IDLE) && !avm_rst && (req0_valid || req1_valid);
    req0_ready   = accept && !pick;
    req1_ready   = accept && pick;
    sel_ref      = pick ? req1_ref      : req0_ref;
    sel_read     = pick ? req1_read     : req0_read;
    sel_ref_len  = pick ? req1_ref_len  : req0_ref_len;
    sel_read_len = pick ? req1_read_len : req0_read_len;
    zero_len     = (sel_ref_len == '0) || (sel_read_len == '0);
    rsp_hs       = (state == RESP) && (grant ? rsp1_ready : rsp0_ready);
    state_nxt    = state;
    case (state)
      IDLE:    if (accept) state_nxt = zero_len ? RESP : ISSUE;
      ISSUE:   if (core_o_ready) state_nxt = WAIT;
      WAIT:    if (core_o_valid || (wd == WD_LAST)) state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      wd         <= '0;
      jobs_q     <= '0;
      ref_q      <= '0;
      read_q     <= '0;
      ref_len_q  <= '0;
      read_len_q <= '0;
      score_q    <= '0;
      row_q      <= '0;
      col_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        grant      <= pick;
        ref_q      <= sel_ref;
        read_q     <= sel_read;
        ref_len_q  <= clamp_len(sel_ref_len);
        read_len_q <= clamp_len(sel_read_len);
        if (zero_len) begin
          score_q <= '0;
          row_q   <= '0;
          col_q   <= '0;
          err_q   <= 1'b0;
        end
      end
      if ((state == ISSUE) && core_o_ready) wd <= '0;
      else if (state == WAIT)               wd <= wd + 1'b1;
      // a core result in the expiry cycle takes priority over the abort
      if (state == WAIT) begin
        if (core_o_valid) begin
          score_q <= core_score;
          row_q   <= core_row;
          col_q   <= core_col;
          err_q   <= 1'b0;
        end else if (wd == WD_LAST) begin
          score_q <= '0;
          row_q   <= '0;
          col_q   <= '0;
          err_q   <= 1'b1;
        end
      end
      if (rsp_hs) begin
        last_grant <= grant;
        if (!err_q) jobs_q <= jobs_q + 16'd1;
      end
    end
  end

  assign core_i_valid  = (state == ISSUE);
  assign core_i_ready  = (state == IDLE) || (state == WAIT);
  assign core_seq_ref  = ref_q;
  assign core_seq_read = read_q;
  assign core_ref_len  = ref_len_q;
  assign core_read_len = read_len_q;
  assign busy          = (state != IDLE);
  assign jobs_done     = jobs_q;
  assign rsp0_valid    = (state == RESP) && !grant;
  assign rsp1_valid    = (state == RESP) && grant;
  assign rsp0_score    = score_q;
  assign rsp0_row      = row_q;
  assign rsp0_col      = col_q;
  assign rsp0_err      = err_q;
  assign rsp1_score    = score_q;
  assign rsp1_row      = row_q;
  assign rsp1_col      = col_q;
  assign rsp1_err      = err_q;

endmodule

// File: tb/tb_sw_core_arbiter.sv
// Directed bench for sw_core_arbiter: single job, clamp/back-pressure, zero length,
// contention, watchdog abort and reset mid-job.
module tb_sw_core_arbiter;

  localparam int SEQ_W = 256, LEN_W = 8, SCORE_W = 10, POS_W = 7;

  logic               avm_clk = 1'b0, avm_rst = 1'b1;
  logic               req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic               req0_ready, req1_ready;
  logic [SEQ_W-1:0]   req0_ref = '0, req0_read = '0, req1_ref = '0, req1_read = '0;
  logic [LEN_W-1:0]   req0_ref_len = '0, req0_read_len = '0, req1_ref_len = '0, req1_read_len = '0;
  logic               rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [SCORE_W-1:0] rsp0_score, rsp1_score;
  logic [POS_W-1:0]   rsp0_row, rsp0_col, rsp1_row, rsp1_col;
  logic               core_i_valid, core_i_ready, busy;
  logic               core_o_ready = 0, core_o_valid = 0;
  logic [SEQ_W-1:0]   core_seq_ref, core_seq_read;
  logic [LEN_W-1:0]   core_ref_len, core_read_len;
  logic [SCORE_W-1:0] core_score = '0;
  logic [POS_W-1:0]   core_row = '0, core_col = '0;
  logic [15:0]        jobs_done;

  int checks = 0;
  int errors = 0;

  sw_core_arbiter #(.TIMEOUT(50)) dut (
    .avm_clk(avm_clk), .avm_rst(avm_rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ref(req0_ref), .req0_read(req0_read),
    .req0_ref_len(req0_ref_len), .req0_read_len(req0_read_len),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ref(req1_ref), .req1_read(req1_read),
    .req1_ref_len(req1_ref_len), .req1_read_len(req1_read_len),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_score(rsp0_score),
    .rsp0_row(rsp0_row), .rsp0_col(rsp0_col), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_score(rsp1_score),
    .rsp1_row(rsp1_row), .rsp1_col(rsp1_col), .rsp1_err(rsp1_err),
    .core_i_valid(core_i_valid), .core_o_ready(core_o_ready),
    .core_seq_ref(core_seq_ref), .core_seq_read(core_seq_read),
    .core_ref_len(core_ref_len), .core_read_len(core_read_len),
    .core_i_ready(core_i_ready), .core_o_valid(core_o_valid),
    .core_score(core_score), .core_row(core_row), .core_col(core_col),
    .busy(busy), .jobs_done(jobs_done)
  );

  always #5 avm_clk = ~avm_clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge avm_clk);
  endtask

  // One core job through ISSUE/WAIT/RESP for requester g; both requesters keep valid.
  task automatic serve(input logic g, input logic [9:0] sc, input logic [6:0] r, input logic [6:0] c,
                       input logic [15:0] jobs_exp);
    #1;
    chk("cont_rdy0", req0_ready, !g);
    chk("cont_rdy1", req1_ready, g);
    cyc(1);
    chk("cont_ivalid", core_i_valid, 1);
    chk("cont_len", core_ref_len, g ? 20 : 10);
    core_o_ready = 1;
    cyc(1);
    core_o_ready = 0;
    cyc(3);
    core_o_valid = 1; core_score = sc; core_row = r; core_col = c;
    cyc(1);
    core_o_valid = 0;
    chk("cont_rsp0v", rsp0_valid, !g);
    chk("cont_rsp1v", rsp1_valid, g);
    chk("cont_score", g ? rsp1_score : rsp0_score, sc);
    if (g) rsp1_ready = 1; else rsp0_ready = 1;
    cyc(1);
    rsp0_ready = 0; rsp1_ready = 0;
    chk("cont_jobs", jobs_done, jobs_exp);
  endtask

  initial begin
    logic [SEQ_W-1:0] ra, rb;
    ra = {8{32'hDEADBEEF}};
    rb = {8{32'h12345678}};

    // reset state, ready forced low while reset is held
    req0_valid = 1;
    @(negedge avm_clk); #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_ivalid", core_i_valid, 0);
    chk("rst_rsp0v", rsp0_valid, 0);
    chk("rst_reflen", core_ref_len, 0);
    req0_valid = 0;
    avm_rst = 0;
    cyc(1);
    chk("rel_iready", core_i_ready, 1);

    // single job on req0
    req0_valid = 1; req0_ref = ra; req0_read = rb; req0_ref_len = 4; req0_read_len = 4;
    #1;
    chk("s_rdy0", req0_ready, 1);
    chk("s_rdy1", req1_ready, 0);
    cyc(1);
    req0_valid = 0;
    chk("s_ivalid", core_i_valid, 1);
    chk("s_busy", busy, 1);
    chk("s_reflen", core_ref_len, 4);
    chk("s_seqref", core_seq_ref === ra, 1);
    core_o_ready = 1;
    cyc(1);
    core_o_ready = 0;
    chk("s_ivalid_wait", core_i_valid, 0);
    chk("s_iready_wait", core_i_ready, 1);
    cyc(19);
    core_o_valid = 1; core_score = 7; core_row = 3; core_col = 3;
    cyc(1);
    core_o_valid = 0;
    chk("s_rsp0v", rsp0_valid, 1);
    chk("s_rsp1v", rsp1_valid, 0);
    chk("s_score", rsp0_score, 7);
    chk("s_row", rsp0_row, 3);
    chk("s_col", rsp0_col, 3);
    chk("s_err", rsp0_err, 0);
    rsp0_ready = 1;
    cyc(1);
    rsp0_ready = 0;
    chk("s_rsp0v_done", rsp0_valid, 0);
    chk("s_jobs", jobs_done, 1);
    chk("s_idle", busy, 0);

    // clamp and back-pressure on req0
    req0_valid = 1; req0_ref_len = 9; req0_read_len = 200; req0_read = ra;
    cyc(1);
    req0_valid = 0;
    chk("c_readlen", core_read_len, 128);
    chk("c_reflen", core_ref_len, 9);
    for (int i = 0; i < 10; i++) begin
      chk("bp_ivalid", core_i_valid, 1);
      chk("bp_seqread", core_seq_read === ra, 1);
      cyc(1);
    end
    core_o_ready = 1;
    cyc(1);
    core_o_ready = 0;
    chk("bp_issued", core_i_valid, 0);
    core_o_valid = 1; core_score = 513; core_row = 100; core_col = 127;
    cyc(1);
    core_o_valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rspv", rsp0_valid, 1);
      chk("bp_score", rsp0_score, 513);
      chk("bp_col", rsp0_col, 127);
      cyc(1);
    end
    rsp0_ready = 1;
    cyc(1);
    rsp0_ready = 0;
    chk("bp_rspv_done", rsp0_valid, 0);
    chk("bp_jobs", jobs_done, 2);

    // zero-length on req1 bypasses the core
    req1_valid = 1; req1_ref_len = 0; req1_read_len = 5;
    #1;
    chk("z_rdy1", req1_ready, 1);
    cyc(1);
    req1_valid = 0;
    chk("z_rsp1v", rsp1_valid, 1);
    chk("z_rsp0v", rsp0_valid, 0);
    chk("z_score", rsp1_score, 0);
    chk("z_err", rsp1_err, 0);
    chk("z_ivalid", core_i_valid, 0);
    rsp1_ready = 1;
    cyc(1);
    rsp1_ready = 0;
    chk("z_ivalid2", core_i_valid, 0);
    chk("z_jobs", jobs_done, 3);

    // contention: grants alternate starting with req0
    req0_valid = 1; req0_ref_len = 10; req0_read_len = 5;
    req1_valid = 1; req1_ref_len = 20; req1_read_len = 5;
    for (int j = 0; j < 8; j++)
      serve(j[0], 10'(100 + j), 7'(j), 7'(j + 1), 16'(4 + j));
    req0_valid = 0; req1_valid = 0;

    // watchdog abort: core accepts but never answers
    req0_valid = 1; req0_ref_len = 4; req0_read_len = 4;
    cyc(1);
    req0_valid = 0;
    core_o_ready = 1;
    cyc(1);
    core_o_ready = 0;
    cyc(49);
    chk("wd_before", rsp0_valid, 0);
    cyc(1);
    chk("wd_rspv", rsp0_valid, 1);
    chk("wd_err", rsp0_err, 1);
    chk("wd_score", rsp0_score, 0);
    rsp0_ready = 1;
    cyc(1);
    rsp0_ready = 0;
    chk("wd_jobs", jobs_done, 11);

    // reset while in ISSUE
    req1_valid = 1; req1_ref_len = 3; req1_read_len = 3;
    cyc(1);
    req1_valid = 0;
    chk("r_ivalid", core_i_valid, 1);
    req0_valid = 1;
    avm_rst = 1;
    #1;
    chk("r_ivalid0", core_i_valid, 0);
    chk("r_busy", busy, 0);
    chk("r_jobs", jobs_done, 0);
    chk("r_rdy0", req0_ready, 0);
    chk("r_reflen", core_ref_len, 0);
    chk("r_rsp1v", rsp1_valid, 0);
    req0_valid = 0;
    cyc(1);
    avm_rst = 0;
    cyc(1);
    chk("r_iready", core_i_ready, 1);
    // stale core result drained in IDLE, nothing returned
    core_o_valid = 1; core_score = 55;
    cyc(1);
    core_o_valid = 0;
    chk("drain_rsp0v", rsp0_valid, 0);
    chk("drain_rsp1v", rsp1_valid, 0);
    chk("drain_score", rsp1_score, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_core_arbiter.md
# sw_core_arbiter

Sequences and shares a single Smith-Waterman core (SW_core) between two independent requesters, e.g. the RS232 host wrapper and an on-chip self-test source. It grants one job at a time with round-robin fairness and latches that job's sequences and lengths. It drives the core's valid/ready handshakes, captures the score and position, and returns them to the granted requester. A watchdog aborts jobs the core never completes.

## Interface
- SEQ_W, 256, packed sequence width (128 bases × 2 bits)
- LEN_W, 8, sequence length width
- SCORE_W, 10, alignment score width
- POS_W, 7, row/column width
- MAX_LEN, 128, largest legal length
- TIMEOUT, 65535, max cycles in WAIT before abort

Ports:
- avm_clk  in  1  clock
- avm_rst  in  1  asynchronous, active-high reset
- req{0,1}_valid  in  1  job offered
- req{0,1}_ready  out  1  job accepted this cycle (comb; forced 0 while avm_rst)
- req{0,1}_ref / req{0,1}_read  in  SEQ_W  packed sequences
- req{0,1}_ref_len / req{0,1}_read_len  in  LEN_W  lengths
- rsp{0,1}_valid  out  1  result available
- rsp{0,1}_ready  in  1  result consumed
- rsp{0,1}_score  out  SCORE_W  alignment score
- rsp{0,1}_row / rsp{0,1}_col  out  POS_W  end position
- rsp{0,1}_err  out  1  1 = job aborted by watchdog
- core_i_valid  out  1  to SW_core i_valid
- core_o_ready  in  1  from SW_core o_ready
- core_seq_ref / core_seq_read  out  SEQ_W  to SW_core
- core_ref_len / core_read_len  out  LEN_W  to SW_core (clamped)
- core_i_ready  out  1  to SW_core i_ready
- core_o_valid  in  1  from SW_core o_valid
- core_score / core_row / core_col  in  SCORE_W/POS_W/POS_W  from SW_core
- busy  out  1  state ≠ IDLE
- jobs_done  out  16  completed jobs, wraps 0xFFFF→0

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**: the pick is the requester with valid high.
  - If both are valid, the pick is the one not equal to last_grant. last_grant resets to 1, so req0 wins first.
  - req{pick}_ready = 1 in the same cycle. On the handshake, latch sequences, lengths and grant id.
  - Lengths above MAX_LEN are clamped to MAX_LEN when latched.
  - If either latched length is 0: go directly to RESP with score=0, row=0, col=0, err=0. The core is not used.
  - Otherwise go to ISSUE.
- **ISSUE**: core_i_valid=1 with latched data held stable. When core_i_valid && core_o_ready, go to WAIT and clear the watchdog.
- **WAIT**: core_i_ready=1; watchdog increments every cycle.
  - When core_o_valid: capture score/row/col, err=0, go to RESP.
  - When the watchdog reaches TIMEOUT with no core_o_valid: score=0, row=0, col=0, err=1, go to RESP.
- **RESP**: rsp{grant}_valid=1 with registered result. The other requester's rsp_valid stays 0.
  - On rsp_ready: last_grant←grant; jobs_done+1 only if err=0; go to IDLE.
- core_i_ready is also 1 in IDLE, so late or stale core results are drained and discarded. Results are captured only in WAIT.
- If core_o_valid coincides with watchdog expiry, the core result wins (err=0).
- Requester inputs are ignored outside IDLE. A requester may hold valid indefinitely.

## Timing
- Reset values: state IDLE, last_grant 1, all rsp_* 0, core_i_valid 0, jobs_done 0, busy 0, watchdog 0, latched data 0. req_ready is 0 while reset is asserted. core_i_ready is 1 after reset release.
- Accept at cycle T → core_i_valid high at T+1.
- If core_o_ready is high at T+1, WAIT starts at T+2.
- core_o_valid at cycle C → rsp_valid at C+1.
- rsp handshake at cycle R → IDLE at R+1 → the next job can be accepted at R+1.
- Zero-length job: accept at T → rsp_valid at T+1.
- All outputs except req_ready and core_i_ready are registered.
- Reset mid-job: immediately return to reset values. The in-flight core job is abandoned; its later result is drained in IDLE.

## Test plan
- **Single job:** req0 offers ref_len=read_len=4. Core model returns score=7, row=3, col=3 after 20 cycles. Expect rsp0_valid with 7/3/3, err=0, jobs_done=1, and no rsp1_valid.
- **Contention:** both requesters hold valid for 4 jobs each. Expect grants in order 0,1,0,1,… and rsp routed only to the owning requester.
- **Zero length:** req1 offers ref_len=0. Expect rsp1_valid one cycle after accept with score=0, err=0, and core_i_valid never asserted.
- **Clamp:** read_len=200. Expect core_read_len=128.
- **Back-pressure:** hold core_o_ready=0 for 10 cycles, then rsp_ready=0 for 5 cycles. Expect core_i_valid and rsp data stable throughout, and one transfer each.
- **Watchdog and reset:** with TIMEOUT=50 and a core that never asserts o_valid, expect rsp err=1 at cycle 51 of WAIT and jobs_done unchanged. Then assert avm_rst during ISSUE and expect all outputs at reset values.
